// File: rtl/gpu_line_scheduler.sv
`default_nettype none

`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

// +--------------------------------------------------------------------------+
// | Module     : gpu_line_scheduler                                          |
// | Description: Round-robin arbiter and sequencer that feeds line commands  |
// |              from two requesters to one Bresenham engine and forwards    |
// |              de-duplicated, colour-tagged pixels to the framebuffer.     |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module gpu_line_scheduler #(
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int CMD_W          = 2*`WIDTH_BITS + 2*`HEIGHT_BITS + 3*`CHANNEL_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req0_valid,
    output logic                        req0_ready,
    input  logic [CMD_W-1:0]            req0_cmd,
    input  logic                        req1_valid,
    output logic                        req1_ready,
    input  logic [CMD_W-1:0]            req1_cmd,
    output logic [`WIDTH_BITS-1:0]      eng_x1,
    output logic [`HEIGHT_BITS-1:0]     eng_y1,
    output logic [`WIDTH_BITS-1:0]      eng_x2,
    output logic [`HEIGHT_BITS-1:0]     eng_y2,
    output logic                        eng_start,
    input  logic                        eng_busy,
    input  logic                        eng_done,
    input  logic [`WIDTH_BITS-1:0]      eng_x,
    input  logic [`HEIGHT_BITS-1:0]     eng_y,
    output logic                        px_valid,
    output logic [`WIDTH_BITS-1:0]      px_x,
    output logic [`HEIGHT_BITS-1:0]     px_y,
    output logic [3*`CHANNEL_BITS-1:0]  px_rgb,
    output logic                        cmd_done,
    output logic                        cmd_err,
    output logic                        cmd_owner,
    output logic                        sched_busy
);

    localparam int c_WB     = `WIDTH_BITS;
    localparam int c_HB     = `HEIGHT_BITS;
    localparam int c_RGB_W  = 3*`CHANNEL_BITS;
    localparam int c_CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_X1_MSB = CMD_W - 1;
    localparam int c_Y1_MSB = c_X1_MSB - c_WB;
    localparam int c_X2_MSB = c_Y1_MSB - c_HB;
    localparam int c_Y2_MSB = c_X2_MSB - c_WB;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_LAUNCH  = 2'd1;
    localparam logic [1:0] c_ST_DRAW    = 2'd2;
    localparam logic [1:0] c_ST_RELEASE = 2'd3;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]          r_state;
    logic                r_last_grant;
    logic                r_owner;
    logic [c_WB-1:0]     r_x1;
    logic [c_HB-1:0]     r_y1;
    logic [c_WB-1:0]     r_x2;
    logic [c_HB-1:0]     r_y2;
    logic [c_RGB_W-1:0]  r_rgb;
    logic                r_eng_start;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_have_prev;
    logic [c_WB-1:0]     r_prev_x;
    logic [c_HB-1:0]     r_prev_y;
    logic                r_px_valid;
    logic [c_WB-1:0]     r_px_x;
    logic [c_HB-1:0]     r_px_y;
    logic [c_RGB_W-1:0]  r_px_rgb;
    logic                r_cmd_done;
    logic                r_cmd_err;
    logic                r_cmd_owner;

    logic                w_idle;
    logic                w_grant0;
    logic                w_grant1;
    logic [CMD_W-1:0]    w_cmd;
    logic                w_timeout;
    logic                w_fwd;

    // Ties go to whichever requester did not win last; reset leaves last=1 so req0 wins first.
    assign w_idle    = (r_state == c_ST_IDLE) && !rst;
    assign w_grant0  = w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1  = w_idle && req1_valid && (!req0_valid || !r_last_grant);
    assign w_cmd     = w_grant1 ? req1_cmd : req0_cmd;
    assign w_timeout = !eng_done && (r_cnt == c_CNT_LAST);
    assign w_fwd     = (r_state == c_ST_DRAW) && eng_busy && !w_timeout &&
                       (!r_have_prev || (eng_x != r_prev_x) || (eng_y != r_prev_y));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_x1         <= '0;
            r_y1         <= '0;
            r_x2         <= '0;
            r_y2         <= '0;
            r_rgb        <= '0;
            r_eng_start  <= 1'b0;
            r_cnt        <= '0;
            r_have_prev  <= 1'b0;
            r_prev_x     <= '0;
            r_prev_y     <= '0;
            r_px_valid   <= 1'b0;
            r_px_x       <= '0;
            r_px_y       <= '0;
            r_px_rgb     <= '0;
            r_cmd_done   <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_cmd_owner  <= 1'b0;
        end else begin
            r_px_valid <= 1'b0;
            r_cmd_done <= 1'b0;
            r_cmd_err  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_x1         <= w_cmd[c_X1_MSB -: c_WB];
                        r_y1         <= w_cmd[c_Y1_MSB -: c_HB];
                        r_x2         <= w_cmd[c_X2_MSB -: c_WB];
                        r_y2         <= w_cmd[c_Y2_MSB -: c_HB];
                        r_rgb        <= w_cmd[c_RGB_W-1:0];
                        r_owner      <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_eng_start  <= 1'b1;
                        r_state      <= c_ST_LAUNCH;
                    end
                end
                c_ST_LAUNCH: begin
                    r_cnt       <= '0;
                    r_have_prev <= 1'b0;
                    r_state     <= c_ST_DRAW;
                end
                c_ST_DRAW: begin
                    // Engine hold steps repeat a coordinate; only forward changes.
                    if (w_fwd) begin
                        r_px_valid  <= 1'b1;
                        r_px_x      <= eng_x;
                        r_px_y      <= eng_y;
                        r_px_rgb    <= r_rgb;
                        r_prev_x    <= eng_x;
                        r_prev_y    <= eng_y;
                        r_have_prev <= 1'b1;
                    end
                    if (eng_done) begin
                        r_cmd_done  <= 1'b1;
                        r_cmd_owner <= r_owner;
                        r_eng_start <= 1'b0;
                        r_state     <= c_ST_RELEASE;
                    end else if (w_timeout) begin
                        r_cmd_err   <= 1'b1;
                        r_cmd_owner <= r_owner;
                        r_eng_start <= 1'b0;
                        r_state     <= c_ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_RELEASE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign eng_x1     = r_x1;
    assign eng_y1     = r_y1;
    assign eng_x2     = r_x2;
    assign eng_y2     = r_y2;
    assign eng_start  = r_eng_start;
    assign px_valid   = r_px_valid;
    assign px_x       = r_px_x;
    assign px_y       = r_px_y;
    assign px_rgb     = r_px_rgb;
    assign cmd_done   = r_cmd_done;
    assign cmd_err    = r_cmd_err;
    assign cmd_owner  = r_cmd_owner;
    assign sched_busy = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_gpu_line_scheduler.sv
`default_nettype none

`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

// +--------------------------------------------------------------------------+
// | Module     : tb_gpu_line_scheduler                                       |
// | Description: Scoreboard bench for gpu_line_scheduler with a stub engine. |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_gpu_line_scheduler;

    localparam int WB    = `WIDTH_BITS;
    localparam int HB    = `HEIGHT_BITS;
    localparam int RGBW  = 3*`CHANNEL_BITS;
    localparam int CMD_W = 2*WB + 2*HB + RGBW;
    localparam int TO    = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [CMD_W-1:0] req0_cmd = '0, req1_cmd = '0;
    logic [WB-1:0]    eng_x1, eng_x2, eng_x;
    logic [HB-1:0]    eng_y1, eng_y2, eng_y;
    logic             eng_start, eng_busy, eng_done;
    logic             px_valid;
    logic [WB-1:0]    px_x;
    logic [HB-1:0]    px_y;
    logic [RGBW-1:0]  px_rgb;
    logic             cmd_done, cmd_err, cmd_owner, sched_busy;

    always #5 clk = ~clk;

    gpu_line_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
        .eng_x1(eng_x1), .eng_y1(eng_y1), .eng_x2(eng_x2), .eng_y2(eng_y2),
        .eng_start(eng_start), .eng_busy(eng_busy), .eng_done(eng_done),
        .eng_x(eng_x), .eng_y(eng_y),
        .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
        .cmd_done(cmd_done), .cmd_err(cmd_err), .cmd_owner(cmd_owner),
        .sched_busy(sched_busy)
    );

    typedef struct { int x; int y; logic [RGBW-1:0] rgb; bit first; } px_t;
    typedef struct { bit owner; bit err; } res_t;
    px_t  px_q[$];
    res_t res_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit        acc0 = 0, acc1 = 0;
    bit        m_last = 1'b1;
    bit        after_cmd = 0;
    bit        consec = 0;
    bit [15:0] eng_hold_mask = '0;
    bit        eng_never_done = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [CMD_W-1:0] mk_cmd(input int x1, input int y1, input int x2,
                                                input int y2, input logic [RGBW-1:0] rgb);
        return {WB'(x1), HB'(y1), WB'(x2), HB'(y2), rgb};
    endfunction

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    function automatic int nsteps(input int x1, input int y1, input int x2, input int y2);
        int ax = (x2 > x1) ? x2 - x1 : x1 - x2;
        int ay = (y2 > y1) ? y2 - y1 : y1 - y2;
        return (ax > ay) ? ax : ay;
    endfunction

    task automatic push_expected(input logic [CMD_W-1:0] c, input bit owner, input bit err);
        int x1 = int'(c[CMD_W-1 -: WB]);
        int y1 = int'(c[CMD_W-1-WB -: HB]);
        int x2 = int'(c[CMD_W-1-WB-HB -: WB]);
        int y2 = int'(c[CMD_W-1-2*WB-HB -: HB]);
        int n  = nsteps(x1, y1, x2, y2);
        px_t  p;
        res_t r;
        for (int k = 0; k <= n; k++) begin
            p.x = x1 + k*sgn(x2 - x1);
            p.y = y1 + k*sgn(y2 - y1);
            p.rgb = c[RGBW-1:0];
            p.first = (k == 0);
            px_q.push_back(p);
        end
        r.owner = owner;
        r.err   = err;
        res_q.push_back(r);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Engine stub: registered response, one point per cycle, optional hold repeats.
    initial begin
        bit s_start, s_rst, p_start, active;
        int ex1, ey1, ex2, ey2, n, idx;
        int qx[$];
        int qy[$];
        p_start = 0; active = 0; idx = 0;
        ex1 = 0; ey1 = 0; ex2 = 0; ey2 = 0;
        eng_busy = 0; eng_done = 0; eng_x = '0; eng_y = '0;
        forever begin
            @(negedge clk);
            s_start = eng_start; s_rst = rst;
            ex1 = int'(eng_x1); ey1 = int'(eng_y1); ex2 = int'(eng_x2); ey2 = int'(eng_y2);
            @(posedge clk);
            #1;
            eng_busy = 0;
            eng_done = 0;
            if (s_rst || !s_start) begin
                active = 0;
            end else if (!p_start) begin
                qx.delete(); qy.delete();
                n = nsteps(ex1, ey1, ex2, ey2);
                for (int k = 0; k <= n; k++) begin
                    qx.push_back(ex1 + k*sgn(ex2 - ex1));
                    qy.push_back(ey1 + k*sgn(ey2 - ey1));
                    if (k < 16 && eng_hold_mask[k]) begin
                        qx.push_back(ex1 + k*sgn(ex2 - ex1));
                        qy.push_back(ey1 + k*sgn(ey2 - ey1));
                    end
                end
                active = 1; idx = 0;
            end
            if (active) begin
                if (idx < qx.size()) begin
                    eng_busy = 1; eng_x = WB'(qx[idx]); eng_y = HB'(qy[idx]); idx++;
                end else if (eng_never_done) begin
                    eng_busy = 1;
                end else begin
                    eng_done = 1; active = 0;
                end
            end
            p_start = s_start && !s_rst;
        end
    end

    // Monitor: arbitration model, endpoint, pixel and completion scoreboard.
    initial begin
        bit          exp_g, prev_start;
        int          launch_cyc, done_cyc, last_px;
        logic [63:0] cur_ep;
        px_t         e;
        res_t        r;
        prev_start = 0; launch_cyc = 0; done_cyc = 0; last_px = 0; cur_ep = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req0_ready || req1_ready) begin
                    if (!req0_valid && !req1_valid)
                        check("ready_no_valid", {req1_ready, req0_ready}, 2'b00);
                    else begin
                        exp_g = (req0_valid && req1_valid) ? !m_last : req1_valid;
                        check("grant", {req1_ready, req0_ready}, exp_g ? 2'b10 : 2'b01);
                        m_last = exp_g;
                        push_expected(exp_g ? req1_cmd : req0_cmd, exp_g, eng_never_done);
                        cur_ep = 64'((exp_g ? req1_cmd : req0_cmd) >> RGBW);
                        if (exp_g) acc1 = 1; else acc0 = 1;
                    end
                end
                if (eng_start && !prev_start) begin
                    launch_cyc = cyc;
                    check("endpoints", {eng_x1, eng_y1, eng_x2, eng_y2}, cur_ep);
                end
                if (eng_done) done_cyc = cyc;
                if (px_valid) begin
                    if (px_q.size() == 0) check("px_unexpected", px_valid, 1'b0);
                    else begin
                        e = px_q.pop_front();
                        check("px_x", px_x, e.x);
                        check("px_y", px_y, e.y);
                        check("px_rgb", px_rgb, e.rgb);
                        if (consec && !e.first) check("px_gap", cyc - last_px, 1);
                        last_px = cyc;
                    end
                end
                if (cmd_done || cmd_err) begin
                    if (res_q.size() == 0) check("cmd_unexpected", {cmd_done, cmd_err}, 2'b00);
                    else begin
                        r = res_q.pop_front();
                        check("cmd_owner", cmd_owner, r.owner);
                        check("cmd_err", cmd_err, r.err);
                        check("cmd_done", cmd_done, !r.err);
                        if (r.err) check("err_time", cyc - launch_cyc, TO + 1);
                        else       check("done_time", cyc - done_cyc, 1);
                        check("px_left", px_q.size(), 0);
                        check("start_release", eng_start, 1'b0);
                        check("busy_release", sched_busy, 1'b1);
                        after_cmd = 1;
                    end
                end else if (after_cmd) begin
                    check("idle_after", sched_busy, 1'b0);
                    after_cmd = 0;
                end
            end
            prev_start = eng_start;
        end
    end

    task automatic present(input bit v0, input logic [CMD_W-1:0] c0,
                           input bit v1, input logic [CMD_W-1:0] c1);
        @(posedge clk);
        #1;
        if (v0) begin req0_cmd = c0; req0_valid = 1; end
        if (v1) begin req1_cmd = c1; req1_valid = 1; end
    endtask

    task automatic step_drop();
        @(posedge clk);
        #1;
        if (acc0) begin req0_valid = 0; acc0 = 0; end
        if (acc1) begin req1_valid = 0; acc1 = 0; end
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        while ((req0_valid || req1_valid || res_q.size() != 0 || sched_busy) && n < 300) begin
            step_drop();
            n++;
        end
        check({tag, "_drain"}, (n < 300), 1'b1);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_busy", sched_busy, 1'b0);
        check("rst_start", eng_start, 1'b0);
        check("rst_outs", {px_valid, cmd_done, cmd_err, cmd_owner, px_x, px_y, px_rgb}, '0);
        check("rst_ep", {eng_x1, eng_y1, eng_x2, eng_y2}, '0);

        // Ties: req0 first after reset, then req1, then a third tie goes back to req0.
        eng_hold_mask = 16'b0010;
        present(1, mk_cmd(2, 3, 4, 5, 24'h112233), 1, mk_cmd(7, 1, 7, 3, 24'h445566));
        wait_quiet("tie1");
        present(1, mk_cmd(0, 9, 0, 9, 24'h778899), 1, mk_cmd(20, 20, 17, 17, 24'hAABBCC));
        wait_quiet("tie2");

        eng_hold_mask = '0; consec = 1;
        present(1, mk_cmd(0, 0, 3, 0, 24'hFF0000), 0, '0);
        wait_quiet("horiz");
        consec = 0;

        present(1, mk_cmd(5, 7, 5, 7, 24'h00FF00), 0, '0);
        wait_quiet("degen");

        eng_hold_mask = 16'b10101;
        present(0, '0, 1, mk_cmd(10, 10, 6, 14, 24'h0000FF));
        wait_quiet("diag");

        eng_hold_mask = '0; eng_never_done = 1;
        present(0, '0, 1, mk_cmd(0, 0, 2, 2, 24'h123456));
        wait_quiet("timeout");
        eng_never_done = 0;

        // Reset in the middle of a long line discards it entirely.
        present(1, mk_cmd(0, 0, 40, 0, 24'h654321), 0, '0);
        n = 0;
        while (!eng_start && n < 50) begin step_drop(); n++; end
        check("long_launch", eng_start, 1'b1);
        repeat (6) step_drop();
        rst = 1;
        px_q.delete(); res_q.delete();
        @(posedge clk);
        #1;
        rst = 0; m_last = 1; after_cmd = 0; acc0 = 0; acc1 = 0; req0_valid = 0;
        @(negedge clk);
        check("midrst_start", eng_start, 1'b0);
        check("midrst_busy", sched_busy, 1'b0);
        check("midrst_outs", {px_valid, cmd_done, cmd_err, cmd_owner, px_rgb}, '0);
        check("midrst_ep", {eng_x1, eng_y1, eng_x2, eng_y2}, '0);
        repeat (3) @(posedge clk);
        check("midrst_quiet", {cmd_done, cmd_err, px_valid}, 3'b000);

        eng_hold_mask = 16'b0100;
        present(0, '0, 1, mk_cmd(1, 2, 1, 5, 24'hCAFE01));
        wait_quiet("after_rst");

        repeat (3) @(posedge clk);
        check("final_px_q", px_q.size(), 0);
        check("final_res_q", res_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end expected end of test");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
